// File: rtl/k2red_shift_pipe.sv
// Purpose : fully pipelined K^2-RED modular reducer for q = k*2^m + 1, k a sum of up to NT powers of two.
// Latency : 4 register stages (S1 operand, S2 K-RED, S3 optional second K-RED, S4 correction), 1 result/cycle.
// Backpr. : all stages advance together when !out_valid || out_ready and hold otherwise; no bubbles on stall.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/cfg_ready  configuration write strobe / accepted when the pipeline is empty
//   Q, M, EXP, EMASK  modulus, shift m, per-term exponents (field i = e_i) and term enables
//   MODE              0: k*A mod q, 1: k^2*A mod q
//   in_valid/in_ready/A    operand stream (2W-bit operand)
//   out_valid/out_ready/C  result stream (W-bit canonical residue)
module k2red_shift_pipe #(
  parameter int W  = 32,
  parameter int NT = 4,
  parameter int EW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [W-1:0]       Q,
  input  logic [EW-1:0]      M,
  input  logic [NT*EW-1:0]   EXP,
  input  logic [NT-1:0]      EMASK,
  input  logic               MODE,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*W-1:0]     A,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       C
);

  // Intermediate residues are signed and need two guard bits over the operand.
  localparam int RW = 2*W + 2;
  typedef logic signed [RW-1:0] res_t;

  // Configuration, only writable while nothing is in flight.
  logic [W-1:0]     q_r;
  logic [EW-1:0]    m_r;
  logic [NT*EW-1:0] exp_r;
  logic [NT-1:0]    emask_r;
  logic             mode_r;

  // Pipeline state.
  logic             v1, v2, v3;
  logic [2*W-1:0]   a1;
  res_t             r2, r3;

  logic             en;
  res_t             a_ext, qx, r2_nxt, r3_nxt;
  logic [W-1:0]     c_nxt;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !cfg_we;
  assign cfg_ready = !(v1 || v2 || v3 || out_valid);

  assign a_ext = {2'b00, a1};
  assign qx    = {{(RW-W){1'b0}}, q_r};

  // One K-RED step: x = hi*2^m + lo with lo in [0, 2^m) (floor split),
  // returns k*lo - hi, which is congruent to k*x because k*2^m = -1 mod q.
  function automatic res_t kred(input res_t             x,
                                input logic [EW-1:0]    m,
                                input logic [NT*EW-1:0] ex,
                                input logic [NT-1:0]    msk);
    res_t lo, hi, acc;
    lo  = x & ~({RW{1'b1}} << m);
    hi  = x >>> m;
    acc = '0;
    for (int i = 0; i < NT; i++) begin
      if (msk[i]) acc = acc + (lo << ex[i*EW +: EW]);
    end
    return acc - hi;
  endfunction

  always_comb begin
    r2_nxt = kred(a_ext, m_r, exp_r, emask_r);
    r3_nxt = mode_r ? kred(r2, m_r, exp_r, emask_r) : r2;
    // In-region residues land in [-q, 2q); the canonical value fits W bits,
    // so the correction add/subtract only needs the low W bits.
    if (r3 < 0)
      c_nxt = r3[W-1:0] + q_r;
    else if (r3 >= qx)
      c_nxt = r3[W-1:0] - q_r;
    else
      c_nxt = r3[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= '0;
      m_r       <= '0;
      exp_r     <= '0;
      emask_r   <= '0;
      mode_r    <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      a1        <= '0;
      r2        <= '0;
      r3        <= '0;
      C         <= '0;
    end else begin
      if (cfg_we && cfg_ready) begin
        q_r     <= Q;
        m_r     <= M;
        exp_r   <= EXP;
        emask_r <= EMASK;
        mode_r  <= MODE;
      end
      if (en) begin
        v1        <= in_valid && in_ready;
        v2        <= v1;
        v3        <= v2;
        out_valid <= v3;
        // Data registers only load behind a valid so C keeps its last result.
        if (in_valid && in_ready) a1 <= A;
        if (v1) r2 <= r2_nxt;
        if (v2) r3 <= r3_nxt;
        if (v3) C  <= c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_k2red_shift_pipe.sv
module tb_k2red_shift_pipe;
  localparam int W  = 32;
  localparam int NT = 4;
  localparam int EW = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic             cfg_ready;
  logic [W-1:0]     Q;
  logic [EW-1:0]    M;
  logic [NT*EW-1:0] EXP;
  logic [NT-1:0]    EMASK;
  logic             MODE;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   A;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     C;

  k2red_shift_pipe #(.W(W), .NT(NT), .EW(EW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .Q(Q), .M(M), .EXP(EXP), .EMASK(EMASK), .MODE(MODE),
    .in_valid(in_valid), .in_ready(in_ready), .A(A),
    .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  bit fixed_rdy = 1'b1;
  bit rand_rdy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: fixed level or random, changed well away from the edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  localparam logic [NT*EW-1:0] EXP_A = {6'd0, 6'd14, 6'd3, 6'd1};  // k = 16394
  localparam logic [NT*EW-1:0] EXP_B = {6'd0, 6'd0, 6'd1, 6'd0};   // k = 3
  localparam logic [NT*EW-1:0] EXP_C = {6'd13, 6'd9, 6'd4, 6'd0};  // k = 8721
  localparam logic [63:0] Q_A = 64'd2148794369;
  localparam logic [63:0] Q_B = 64'd3221225473;
  localparam logic [63:0] Q_C = 64'd2286157825;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Reference: k = sum of enabled 2^e_i; result = k*A or k^2*A, reduced mod q.
  function automatic logic [63:0] kval(input logic [NT*EW-1:0] ex, input logic [NT-1:0] msk);
    logic [63:0] k;
    k = 64'd0;
    for (int i = 0; i < NT; i++)
      if (msk[i]) k = k + (64'd1 << ex[i*EW +: EW]);
    return k;
  endfunction

  function automatic logic [63:0] ref_red(input logic [63:0] a, input logic [63:0] q,
                                          input logic [63:0] k, input bit mode);
    logic [127:0] p, r, mul;
    mul = mode ? {64'd0, k} * {64'd0, k} : {64'd0, k};
    p   = {64'd0, a} * mul;
    r   = p % {64'd0, q};
    return r[63:0];
  endfunction

  // Scoreboard state.
  logic [63:0] sh_q = 64'd0;
  logic [63:0] sh_k = 64'd0;
  bit          sh_mode = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          got_cyc[$];
  bit          prev_stall = 1'b0;
  logic [W-1:0] prev_c;

  // Compare process: every negedge, handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sh_q = 64'd0; sh_k = 64'd0; sh_mode = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_c_stable", 64'(C), 64'(prev_c));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got C=%0d, expected no result", C);
        end else begin
          check("result", 64'(C), exp_q.pop_front());
        end
        got_q.push_back(64'(C));
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_red(A, sh_q, sh_k, sh_mode));
        acc_cnt++;
      end
      if (cfg_we && cfg_ready) begin
        sh_q = 64'(Q); sh_k = kval(EXP, EMASK); sh_mode = MODE;
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = C;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    A = a;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      tick();
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: operand %0d in_ready stayed 0, expected 1", a);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    fixed_rdy = 1'b1;
    rand_rdy  = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && cfg_ready;
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
    end
  endtask

  task automatic cfg_write(input logic [63:0] q, input logic [EW-1:0] m,
                           input logic [NT*EW-1:0] ex, input logic [NT-1:0] msk, input bit mode);
    drain();
    cfg_we = 1'b1; Q = q[W-1:0]; M = m; EXP = ex; EMASK = msk; MODE = mode;
    @(negedge clk);
    check("cfg_ready_empty", 64'(cfg_ready), 64'd1);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic check_got(input string name, input int idx, input logic [63:0] expv);
    if (idx >= got_q.size()) begin
      checks++; errors++;
      $display("FAIL %s: got no result at index %0d, expected %0d", name, idx, expv);
    end else begin
      check(name, got_q[idx], expv);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_acc;
    logic [63:0] a, lim;
    rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; A = '0;
    Q = '0; M = '0; EXP = '0; EMASK = '0; MODE = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c", 64'(C), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    rst = 1'b0;

    // 1. latency, then a back-to-back stream.
    cfg_write(Q_A, 6'd17, EXP_A, 4'b0111, 1'b1);
    send(64'd0); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("latency_first", 64'(out_valid), 64'd1);
    check("latency_c", 64'(C), 64'd0);
    tick();
    drain();
    base = got_q.size();
    send(64'd0); send(64'd1); send(Q_A); idle();
    drain();
    check_got("stream_a0", base,     64'd0);
    check_got("stream_a1", base + 1, 64'd268763236);
    check_got("stream_aq", base + 2, 64'd0);
    if (got_q.size() >= base + 3) begin
      check("stream_consec1", 64'(got_cyc[base+1] - got_cyc[base]), 64'd1);
      check("stream_consec2", 64'(got_cyc[base+2] - got_cyc[base+1]), 64'd1);
    end

    // 2. negative intermediate and a full-width operand.
    base = got_q.size();
    send(64'd131072); send(64'd2500883870215315764); idle();
    drain();
    check_got("a_2pow17", base, 64'd2148777975);

    // 3. single K-RED: k*2^m = -1 mod q.
    cfg_write(Q_A, 6'd17, EXP_A, 4'b0111, 1'b0);
    base = got_q.size();
    send(64'd1); send(64'd131072); idle();
    drain();
    check_got("mode0_a1", base, 64'd16394);
    check_got("mode0_2pow17", base + 1, 64'd2148794368);

    // 4. backpressure.
    cfg_write(Q_A, 6'd17, EXP_A, 4'b0111, 1'b1);
    base = got_q.size();
    base_acc = acc_cnt;
    fixed_rdy = 1'b0;
    tick();
    fork
      begin
        for (int n = 1; n <= 6; n++) send(64'(n));
        idle();
      end
      begin
        repeat (9) tick();
        check("held_ops", 64'(acc_cnt - base_acc), 64'd4);
        check("held_in_ready", 64'(in_ready), 64'd0);
        fixed_rdy = 1'b1;
      end
    join
    drain();
    for (int n = 1; n <= 6; n++)
      check_got("bp_order", base + n - 1, 64'd268763236 * 64'(n));

    // 5. config writes around in-flight operands.
    base = got_q.size();
    send(64'd1); idle();
    cfg_we = 1'b1; Q = Q_B[W-1:0]; M = 6'd30; EXP = EXP_B; EMASK = 4'b0011; MODE = 1'b1;
    @(negedge clk);
    check("cfg_busy_ready", 64'(cfg_ready), 64'd0);
    tick();
    cfg_we = 1'b0;
    drain();
    check_got("cfg_ignored", base, 64'd268763236);
    base = got_q.size();
    cfg_we = 1'b1; in_valid = 1'b1; A = 64'd5;
    @(negedge clk);
    check("cfg_win_ready", 64'(cfg_ready), 64'd1);
    check("cfg_win_in_ready", 64'(in_ready), 64'd0);
    tick();
    cfg_we = 1'b0;
    send(64'd5); idle();
    drain();
    check_got("cfg_taken", base, 64'd45);

    // Randomized operands over three moduli, both modes, random backpressure.
    for (int c = 0; c < 3; c++) begin
      for (int md = 0; md < 2; md++) begin
        logic [63:0] qq;
        logic [EW-1:0] mm;
        if (c == 0)      begin qq = Q_A; mm = 6'd17; cfg_write(qq, mm, EXP_A, 4'b0111, md[0]); end
        else if (c == 1) begin qq = Q_B; mm = 6'd30; cfg_write(qq, mm, EXP_B, 4'b0011, md[0]); end
        else             begin qq = Q_C; mm = 6'd18; cfg_write(qq, mm, EXP_C, 4'b1111, md[0]); end
        lim = qq << mm;
        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
          a = {$urandom, $urandom};
          if (md == 0) a = a % lim;
          if ($urandom_range(0, 3) == 0) begin idle(); tick(); end
          send(a);
        end
        idle();
        drain();
      end
    end

    // 6. reset with operands in flight.
    cfg_write(Q_A, 6'd17, EXP_A, 4'b0111, 1'b1);
    base = got_q.size();
    send(64'd7); send(64'd8); send(64'd9); idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_c", 64'(C), 64'd0);
    check("rst_mid_cfg_ready", 64'(cfg_ready), 64'd1);
    repeat (10) tick();
    check("rst_no_stale", 64'(got_q.size()), 64'(base));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
